// File: rtl/dbus_pkg.sv
// Shared types and helpers for the data-bus initiator: access sizes, FSM states,
// the registered bus payload, and the lane-enable/misalignment rules.
package dbus_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dbus_state_t;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dbus_req_t;

  function automatic logic [BE_W-1:0] be_for(input logic [1:0] size, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (size)
      LSU_BYTE: be = 4'b0001 << off;
      LSU_HALF: be = 4'b0011 << off;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Size 3 has no legal encoding, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      LSU_BYTE: mis = 1'b0;
      LSU_HALF: mis = off[0];
      LSU_WORD: mis = (off != 2'd0);
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_bus.sv
// Single-outstanding data bus between an initiator and memory/peripherals.
interface data_bus;
  import dbus_pkg::*;

  logic            req;
  logic            we;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dbus_lane_align.sv
// Byte-lane steering: store data and byte enables toward the bus, and load data
// extraction with sign/zero extension back toward the core.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]      wr_size,
  input  logic [1:0]      wr_off,
  input  logic [XLEN-1:0] wr_data,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] wdata_c,
  input  logic [1:0]      rd_size,
  input  logic [1:0]      rd_off,
  input  logic            rd_unsigned,
  input  logic [XLEN-1:0] rd_lanes,
  output logic [XLEN-1:0] rdata_c
);

  logic [XLEN-1:0] rd_shift;

  always_comb begin
    be_c     = be_for(wr_size, wr_off);
    wdata_c  = wr_data << {wr_off, 3'b000};
    rd_shift = rd_lanes >> {rd_off, 3'b000};
    case (rd_size)
      LSU_BYTE: rdata_c = {{24{!rd_unsigned && rd_shift[7]}}, rd_shift[7:0]};
      LSU_HALF: rdata_c = {{16{!rd_unsigned && rd_shift[15]}}, rd_shift[15:0]};
      default:  rdata_c = rd_shift;
    endcase
  end

endmodule

// File: rtl/dbus_master.sv
// Load/store unit bus initiator: turns one core request into one data_bus
// transaction with lane steering, misalignment rejection and a response timeout.
module dbus_master
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_busy,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_misaligned,
  output logic            lsu_err,
  data_bus.master         dbus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  dbus_state_t     state_q, state_d;
  dbus_req_t       pl_q, pl_d;
  logic            req_q, req_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            pend_mis_q, pend_mis_d;
  logic            busy_q;
  logic            done_q, done_d;
  logic            mis_q, mis_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] rdata_c;
  logic            timeout_c;

  dbus_lane_align u_lane_align (
    .wr_size     (lsu_size),
    .wr_off      (lsu_addr[1:0]),
    .wr_data     (lsu_wdata),
    .be_c        (be_c),
    .wdata_c     (wdata_c),
    .rd_size     (size_q),
    .rd_off      (off_q),
    .rd_unsigned (uns_q),
    .rd_lanes    (dbus.rdata),
    .rdata_c     (rdata_c)
  );

  // Next-state and next-output logic; a misaligned access spends one silent
  // cycle in RESP before its done pulse.
  always_comb begin
    state_d    = state_q;
    pl_d       = pl_q;
    req_d      = req_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    cnt_d      = cnt_q;
    pend_mis_d = pend_mis_q;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    timeout_c  = TO_EN && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (lsu_req) begin
          if (is_misaligned(lsu_size, lsu_addr[1:0])) begin
            pend_mis_d = 1'b1;
            state_d    = RESP;
          end else begin
            pl_d.we    = lsu_we;
            pl_d.be    = be_c;
            pl_d.addr  = {lsu_addr[XLEN-1:2], 2'b00};
            pl_d.wdata = wdata_c;
            off_d      = lsu_addr[1:0];
            size_d     = lsu_size;
            uns_d      = lsu_unsigned;
            req_d      = 1'b1;
            cnt_d      = '0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dbus.gnt) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end else if (timeout_c) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dbus.rvalid) begin
          done_d  = 1'b1;
          rdata_d = pl_q.we ? '0 : rdata_c;
          state_d = RESP;
        end else if (timeout_c) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (pend_mis_q) begin
          pend_mis_d = 1'b0;
          done_d     = 1'b1;
          mis_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pl_q       <= '0;
      req_q      <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      cnt_q      <= '0;
      pend_mis_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pl_q       <= pl_d;
      req_q      <= req_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      cnt_q      <= cnt_d;
      pend_mis_q <= pend_mis_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign dbus.req       = req_q;
  assign dbus.we        = pl_q.we;
  assign dbus.be        = pl_q.be;
  assign dbus.addr      = pl_q.addr;
  assign dbus.wdata     = pl_q.wdata;
  assign lsu_busy       = busy_q;
  assign lsu_done       = done_q;
  assign lsu_misaligned = mis_q;
  assign lsu_err        = err_q;
  assign lsu_rdata      = rdata_q;

endmodule

// File: tb/tb_dbus_master.sv
// Directed and randomized checks of dbus_master against a byte-level memory
// model and a configurable-latency slave.
module tb_dbus_master;
  import dbus_pkg::*;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_done, lsu_misaligned, lsu_err;
  logic [31:0] lsu_rdata;

  data_bus bus ();

  dbus_master #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req        (lsu_req),
    .lsu_we         (lsu_we),
    .lsu_size       (lsu_size),
    .lsu_unsigned   (lsu_unsigned),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_busy       (lsu_busy),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_misaligned (lsu_misaligned),
    .lsu_err        (lsu_err),
    .dbus           (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave: grants after gnt_delay stalled cycles, answers rv_delay cycles after the grant.
  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];
  int          gnt_delay = 0, rv_delay = 0, stall_cnt = 0, rv_cnt = 0;
  bit          rv_never = 1'b0, rv_pend = 1'b0, force_rv = 1'b0;
  logic [31:0] rv_data = '0;
  logic [31:0] nw;

  assign bus.gnt    = bus.req && (stall_cnt >= gnt_delay);
  assign bus.rvalid = (rv_pend && (rv_cnt >= rv_delay)) || force_rv;
  assign bus.rdata  = rv_data;

  always @(posedge clk) begin
    if (bus.req && !bus.gnt) stall_cnt <= stall_cnt + 1;
    else                     stall_cnt <= 0;
    if (bus.req && bus.gnt) begin
      nw = mem[bus.addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (bus.we && bus.be[b]) nw[8*b +: 8] = bus.wdata[8*b +: 8];
      mem[bus.addr[7:2]] <= nw;
      rv_data <= mem[bus.addr[7:2]];
      rv_pend <= !rv_never;
      rv_cnt  <= 0;
    end else if (rv_pend) begin
      if (bus.rvalid) rv_pend <= 1'b0;
      else            rv_cnt  <= rv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    mem[a[7:2]] <= w;
    for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'(i)}] = w[8*i +: 8];
  endtask

  // Load value as the core should see it, assembled from individual bytes.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit uns);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[8'(a + 32'(i))]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic access(input string tag, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int g, input int r, input bit never, input bit noise);
    int n, off, exp_lat, exp_reqc, req_c, done_k;
    bit mis, err, seen, stable;
    logic [31:0] exp_rd, exp_wd, f_addr, f_wdata, got_rd;
    logic [3:0]  exp_be, f_be;
    logic        f_we, got_mis, got_err;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    mis = (size == 2'd3) || ((off % n) != 0);
    err = !mis && (never || g >= int'(T));
    exp_lat  = mis ? 1 : err ? int'(T) : 2 + g + r;
    exp_reqc = mis ? 0 : (g >= int'(T)) ? int'(T) : g + 1;
    exp_be = '0;
    for (int i = 0; i < n; i++) if (!mis && off + i < 4) exp_be[off + i] = 1'b1;
    exp_wd = wdata << (8 * off);
    exp_rd = we ? 32'h0 : ref_load(addr, n, uns);
    gnt_delay = g; rv_delay = r; rv_never = never;
    f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0; got_rd = '0; got_mis = 1'b0; got_err = 1'b0;

    @(negedge clk);
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    @(posedge clk); #1;
    lsu_req = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_we = 1'($urandom_range(0, 1));
    req_c = 0; done_k = -1; seen = 1'b0; stable = 1'b1;
    for (int k = 0; k < 40 && done_k < 0; k++) begin
      @(negedge clk);
      if (bus.req) begin
        if (!seen) begin
          f_addr = bus.addr; f_wdata = bus.wdata; f_be = bus.be; f_we = bus.we; seen = 1'b1;
        end else if (bus.addr !== f_addr || bus.wdata !== f_wdata || bus.be !== f_be || bus.we !== f_we) begin
          stable = 1'b0;
        end
        req_c++;
      end
      if (lsu_done) begin
        done_k = k; got_rd = lsu_rdata; got_mis = lsu_misaligned; got_err = lsu_err;
        lsu_req = 1'b0;
      end else if (noise) begin
        lsu_req = 1'($urandom_range(0, 1)); lsu_addr = $urandom;
      end
    end
    lsu_req = 1'b0;

    check({tag, ":latency"}, 32'(done_k), 32'(exp_lat));
    check({tag, ":req_cycles"}, 32'(req_c), 32'(exp_reqc));
    check({tag, ":misaligned"}, 32'(got_mis), 32'(mis));
    check({tag, ":err"}, 32'(got_err), 32'(err));
    if (seen) begin
      check({tag, ":addr"}, f_addr, addr & 32'hFFFF_FFFC);
      check({tag, ":be"}, 32'(f_be), 32'(exp_be));
      check({tag, ":we"}, 32'(f_we), 32'(we));
      check({tag, ":wdata"}, f_wdata, exp_wd);
      check({tag, ":stable"}, 32'(stable), 32'd1);
    end
    if (!mis && !err) check({tag, ":rdata"}, got_rd, exp_rd);
    @(negedge clk);
    check({tag, ":idle_after"}, 32'({lsu_done, lsu_busy, bus.req}), 32'd0);

    if (we && !mis && g < int'(T))
      for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [1:0]  sz;
    int          n, off, any_done;
    logic [31:0] a;

    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = '0; lsu_unsigned = 1'b0;
    lsu_addr = '0; lsu_wdata = '0;
    for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:ctrl", 32'({lsu_busy, lsu_done, lsu_misaligned, lsu_err, bus.req, bus.we}), 32'd0);
    check("reset:rdata", lsu_rdata, 32'd0);
    check("reset:addr", bus.addr, 32'd0);
    check("reset:wdata_be", bus.wdata | 32'(bus.be), 32'd0);
    rst_n = 1'b1;

    set_word(32'h100, 32'hDEADBEEF);
    access("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 1'b0, 1'b0);
    set_word(32'h100, 32'h80112233);
    access("lb_103", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, 1'b0, 1'b0);
    access("lbu_103", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, 1'b0, 1'b0);
    access("lh_102", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, 0, 1'b0, 1'b0);
    access("sh_0a2", 1'b1, 2'd1, 1'b0, 32'h0A2, 32'h0000ABCD, 0, 1, 1'b0, 1'b0);
    access("lw_0a0", 1'b0, 2'd2, 1'b0, 32'h0A0, 32'h0, 0, 0, 1'b0, 1'b0);
    access("stall5", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5, 0, 1'b0, 1'b1);
    access("mis_lw_101", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 0, 1'b0, 1'b1);
    access("mis_size3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 0, 1'b0, 1'b0);
    access("gnt_at_limit", 1'b0, 2'd2, 1'b0, 32'h108, 32'h0, int'(T) - 1, 0, 1'b0, 1'b0);
    access("rv_at_limit", 1'b1, 2'd0, 1'b0, 32'h10D, 32'h5A, 0, int'(T) - 2, 1'b0, 1'b0);
    access("to_no_rvalid", 1'b0, 2'd2, 1'b0, 32'h110, 32'h0, 0, 0, 1'b1, 1'b0);
    access("to_no_gnt", 1'b1, 2'd2, 1'b0, 32'h114, 32'h12345678, 20, 0, 1'b0, 1'b0);

    // A late response after a timeout must not produce a completion.
    @(negedge clk); force_rv = 1'b1;
    @(negedge clk); force_rv = 1'b0;
    check("late_rvalid", 32'({lsu_done, lsu_busy, lsu_err, bus.req}), 32'd0);

    // Reset while waiting for a response.
    gnt_delay = 0; rv_never = 1'b1;
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h0000_0040; lsu_wdata = 32'hCAFEF00D;
    @(posedge clk); #1; lsu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst:wait", 32'({lsu_busy, bus.req}), 32'b10);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst:ctrl", 32'({lsu_busy, lsu_done, lsu_misaligned, lsu_err, bus.req, bus.we}), 32'd0);
    check("mid_rst:addr", bus.addr, 32'd0);
    check("mid_rst:wdata", bus.wdata, 32'd0);
    check("mid_rst:be_rdata", lsu_rdata | 32'(bus.be), 32'd0);
    rst_n = 1'b1;
    any_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (lsu_done || lsu_busy) any_done++;
    end
    check("mid_rst:silent", 32'(any_done), 32'd0);
    rv_never = 1'b0;
    set_word(32'h040, $urandom);
    @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      sz  = 2'($urandom_range(0, 2));
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off = int'($urandom_range(0, 3)) & ~(n - 1);
      if ($urandom_range(0, 7) == 0) begin
        sz  = 2'($urandom_range(1, 3));
        off = (sz == 2'd1) ? 2 * int'($urandom_range(0, 1)) + 1 :
              (sz == 2'd2) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      end
      a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 63) << 2) | 32'(off);
      access($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0,
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
Name: dbus_master

Overview:
- Initiator (master) end of the `data_bus` interface, driving `data_bus.master dbus` toward data memory and peripherals.
- Converts one core load/store request into exactly one `data_bus` transaction:
  - byte-enable generation and write-lane steering;
  - read-lane extraction with sign or zero extension;
  - misalignment check;
  - response timeout.
- Sits between the core memory stage and the data interconnect; at most one transaction is outstanding.

Parameters:
- `TIMEOUT_CYCLES`, 256, cycles spent in `REQ` plus `WAIT` before the transaction is aborted with `lsu_err`; 0 disables the timeout.
- `CNT_W`, 9, width of the timeout counter; must be at least clog2(`TIMEOUT_CYCLES` + 1).

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `lsu_req`  in  1  core request strobe; sampled only while `lsu_busy` = 0
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_size`  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned
- `lsu_unsigned`  in  1  zero-extend load data (LBU/LHU)
- `lsu_addr`  in  32  byte address
- `lsu_wdata`  in  32  store data, right-aligned
- `lsu_busy`  out  1  transaction in progress
- `lsu_done`  out  1  one-cycle completion pulse
- `lsu_rdata`  out  32  extended load data; valid while `lsu_done` = 1, 0 for stores
- `lsu_misaligned`  out  1  qualifies `lsu_done`: misaligned access, no bus cycle issued
- `lsu_err`  out  1  qualifies `lsu_done`: timeout abort
- `dbus`  modport  `data_bus.master`  outputs `req`, `we`, `be`[3:0], `addr`[31:0], `wdata`[31:0]; inputs `gnt`, `rvalid`, `rdata`[31:0]

Behaviour:
- Reset (`rst_n` = 0 at a clk edge):
  - state returns to `IDLE` and all outputs go to 0, including `dbus.req`, `dbus.we`, `dbus.be`, `dbus.addr` and `dbus.wdata`;
  - an in-flight transaction is dropped silently and no `lsu_done` is produced.
- FSM states: `IDLE`, `REQ`, `WAIT`, `RESP`. `lsu_busy` = (state != `IDLE`).
- `IDLE`, on `lsu_req` = 1:
  - Misaligned access (half with `addr[0]` = 1, word with `addr[1:0]` != 0, or size 3): go to `RESP` with `lsu_misaligned` set.
  - Otherwise:
    - register the request;
    - `dbus.addr` = {`lsu_addr`[31:2], 2'b00};
    - `be`: byte 4'b0001 << `addr[1:0]`; half 4'b0011 << `addr[1:0]`; word 4'b1111;
    - `wdata` = `lsu_wdata` shifted left by 8 × `addr[1:0]`;
    - go to `REQ`.
- `REQ`:
  - `dbus.req` = 1; `addr`, `we`, `be` and `wdata` are held stable until `gnt`.
  - On `gnt` = 1: go to `WAIT`; `req` drops in the next cycle.
- `WAIT`:
  - `req` = 0.
  - On `rvalid` = 1:
    - for loads, capture `rdata >> (8 × offset)`, then sign- or zero-extend from bit 7 (byte) or bit 15 (half);
    - for stores, `lsu_rdata` = 0;
    - go to `RESP`.
  - The slave asserts `rvalid` for stores as well as loads; stores complete on `rvalid`, not on `gnt`.
- `RESP`: `lsu_done` = 1 for exactly one cycle with registered `lsu_rdata`, `lsu_misaligned` and `lsu_err`; go to `IDLE`. The flags are 0 whenever `lsu_done` = 0.
- Latency:
  - Against a zero-wait slave (`gnt` = `req` combinationally, `rvalid` one cycle after `gnt`), `lsu_req` sampled at edge N gives `req` high after N, `rvalid` after N+1, and `lsu_done` high after edge N+2.
  - A misaligned access gives `lsu_done` after edge N+1.
  - Earliest next request: the cycle after `lsu_done`.
- Timeout:
  - The counter clears when leaving `IDLE` and increments each cycle in `REQ` or `WAIT`.
  - When it reaches `TIMEOUT_CYCLES` - 1 without the awaited `gnt`/`rvalid`: drop `req` and go to `RESP` with `lsu_err` = 1.
  - An awaited event arriving in that same cycle takes priority over the timeout.
- Spurious inputs: `rvalid` in `IDLE`, `REQ` or `RESP`, or `gnt` outside `REQ`, is ignored; this includes a late `rvalid` after a timeout.
- `lsu_req` while busy is ignored; the core must hold or re-issue it.

Decomposition:
- Package `dbus_pkg`:
  - `lsu_size_t` enum (`LSU_BYTE`, `LSU_HALF`, `LSU_WORD`);
  - `dbus_state_t` enum;
  - `be_for()` and `is_misaligned()` functions.
- Sub-module `dbus_lane_align` (combinational):
  - write steering and `be` generation;
  - read extraction and extension.
  It is instantiated once and unit-testable on its own.

Test Plan:
- Zero-wait slave; LW at 0x100 with memory 0xDEADBEEF -> `req` for 1 cycle, `be` = 4'b1111, `lsu_done` 3 cycles after request with `lsu_rdata` = 0xDEADBEEF.
- LB at 0x103 with word 0x80112233 -> `be` = 4'b1000, `lsu_rdata` = 0xFFFFFF80; LBU at 0x103 -> 0x00000080; LH at 0x102 -> 0xFFFF8011.
- SH at 0x0A2, `lsu_wdata` = 0x0000ABCD -> `dbus.we` = 1, `be` = 4'b1100, `wdata` = 0xABCD0000, `addr` = 0x0A0; `lsu_done` follows `rvalid` with `lsu_rdata` = 0.
- Slave withholds `gnt` for 5 cycles -> `req`, `addr`, `be` and `wdata` stay stable for 6 cycles, completion is normal, and `lsu_req` pulses while busy are ignored.
- LW at 0x101 -> no `req` at all; `lsu_done` plus `lsu_misaligned` after 2 cycles. Size 3 at 0x100 -> same response.
- `TIMEOUT_CYCLES` = 8 with the slave never asserting `rvalid` -> `lsu_done` plus `lsu_err` after the timeout and `lsu_busy` falls. A late `rvalid` is then ignored, and `rst_n` low mid-`WAIT` returns to `IDLE` with all outputs 0.
